// File: rtl/hex_display_ctrl.sv
// Registered multi-digit 7-segment driver: capture, decode, blank, blink.
// Glyphs are built active-low and inverted on the way out when needed.
module hex_display_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    blink_phase
);

  localparam int CW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] POL =
    SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic [6:0] GLYPH0 = 7'b1000000 ^ POL;

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    zero_above;
  logic                    blank;
  logic                    cnt_wrap;

  function automatic logic [6:0] glyph(
    input logic [3:0] n
  );
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_comb begin
    value_d  = load ? value : value_q;
    cnt_wrap = (cnt_q == CNT_MAX);
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    phase_d  = phase_q ^ cnt_wrap;

    // Digit 0 is never a leading zero, so zero shows as "0".
    lz         = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (value_q[4*i +: 4] == 4'h0);
      lz[i]      = zero_above & (i != 0);
    end

    seg_d = '0;
    blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank = ~digit_en[i]
            | (blink_en[i] & ~phase_q)
            | (blank_lz & lz[i]);
      seg_d[7*i +: 7] = (blank ? 7'h7F : glyph(value_q[4*i +: 4])) ^ POL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      seg_q   <= {NUM_DIGITS{GLYPH0}};
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign seg         = seg_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed plus random bench for hex_display_ctrl against a
// cycle-count based reference model.
module tb_hex_display_ctrl;

  localparam int ND = 8;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [31:0]   value;
  logic          blank_lz;
  logic [7:0]    digit_en;
  logic [7:0]    blink_en;
  logic [55:0]   seg;
  logic          blink_phase;

  logic          load2;
  logic [7:0]    value2;
  logic          blank_lz2;
  logic [1:0]    digit_en2;
  logic [1:0]    blink_en2;
  logic [13:0]   seg2;
  logic          blink_phase2;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_val;
  int          m_n;

  logic [6:0] gly [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  hex_display_ctrl #(
    .NUM_DIGITS(ND), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .blank_lz(blank_lz), .digit_en(digit_en),
    .blink_en(blink_en), .seg(seg), .blink_phase(blink_phase)
  );

  hex_display_ctrl #(
    .NUM_DIGITS(2), .BLINK_DIV(3), .SEG_ACTIVE_LOW(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .value(value2),
    .blank_lz(blank_lz2), .digit_en(digit_en2),
    .blink_en(blink_en2), .seg(seg2), .blink_phase(blink_phase2)
  );

  always #5 clk = ~clk;

  // Phase after n free-running edges since reset: toggles every BD edges.
  function automatic logic ref_phase(input int n);
    return ((n / BD) % 2) == 0;
  endfunction

  function automatic logic [55:0] ref_seg(
    input logic [31:0] v, input logic lzb,
    input logic [7:0] den, input logic [7:0] ben,
    input logic ph
  );
    logic [55:0] s;
    logic        b;
    s = '0;
    for (int i = 0; i < ND; i++) begin
      b = !den[i] || (ben[i] && !ph)
        || (lzb && i > 0 && (v >> (4 * i)) == 0);
      s[7*i +: 7] = b ? 7'h7F : gly[(v >> (4 * i)) & 32'hF];
    end
    return s;
  endfunction

  task automatic chk(
    input string tag, input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [55:0] e;
    if (!rst_n) e = {ND{7'b1000000}};
    else e = ref_seg(m_val, blank_lz, digit_en, blink_en,
                     ref_phase(m_n));
    @(posedge clk);
    if (!rst_n) begin
      m_val = '0;
      m_n   = 0;
    end else begin
      if (load) m_val = value;
      m_n++;
    end
    #1;
    chk("seg", 64'(seg), 64'(e));
    chk("phase", 64'(blink_phase), 64'(ref_phase(m_n)));
  endtask

  initial begin
    logic [55:0] saved;
    int sh;
    rst_n = 0; load = 0; value = '0; blank_lz = 0;
    digit_en = 8'hFF; blink_en = 8'h00;
    load2 = 0; value2 = '0; blank_lz2 = 0;
    digit_en2 = 2'b11; blink_en2 = 2'b00;
    m_val = '0; m_n = 0;

    tick();
    chk("rst_seg", 64'(seg), 64'({8{7'b1000000}}));
    chk("rst_phase", 64'(blink_phase), 64'(1));
    rst_n = 1;

    load = 1; value = 32'h0000_00F1; tick();
    load = 0; tick();
    chk("t1_d0", 64'(seg[6:0]), 64'(7'b1111001));
    chk("t1_d1", 64'(seg[13:7]), 64'(7'b0001110));
    chk("t1_up", 64'(seg[55:14]), 64'({6{7'b1000000}}));

    load = 1; value = 32'hA8D4_3C5E; tick();
    load = 0; tick();
    chk("t2_d2", 64'(seg[20:14]), 64'(7'b1000110));
    chk("t2_d6", 64'(seg[48:42]), 64'(7'b0000000));
    chk("t2_d7", 64'(seg[55:49]), 64'(7'b0001000));
    saved = seg;
    value = 32'h1234_5678; tick(); tick();
    chk("t2_hold", 64'(seg), 64'(saved));

    blank_lz = 1; load = 1; value = 32'h20; tick();
    load = 0; tick();
    chk("t3_d1", 64'(seg[13:7]), 64'(7'b0100100));
    chk("t3_d0", 64'(seg[6:0]), 64'(7'b1000000));
    chk("t3_up", 64'(seg[55:14]), 64'({6{7'h7F}}));
    load = 1; value = 32'h0; tick();
    load = 0; tick();
    chk("t3_zero", 64'(seg), 64'({{7{7'h7F}}, 7'b1000000}));

    blank_lz = 0; load = 1; value = 32'h1; tick();
    load = 0; blink_en = 8'h01;
    for (int i = 0; i < 16; i++) tick();
    blink_en = 8'h00;

    digit_en = 8'hFE; blink_en = 8'h01;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_blank", 64'(seg[6:0]), 64'(7'h7F));
    end
    blink_en = 8'h00; digit_en = 8'hFF;
    load = 1; rst_n = 0; value = 32'hFFFF_FFFF; tick();
    chk("t5_rst", 64'(seg), 64'({8{7'b1000000}}));
    load = 0; rst_n = 1; tick();
    chk("t5_val0", 64'(seg), 64'({8{7'b1000000}}));

    for (int i = 0; i < 400; i++) begin
      sh = $urandom_range(0, 8);
      value = (sh == 8) ? 32'h0 : ($urandom >> (4 * sh));
      load = $urandom_range(0, 1);
      blank_lz = $urandom_range(0, 1);
      digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      blink_en = 8'($urandom);
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end
    rst_n = 1;

    load2 = 1; value2 = 8'h38; tick();
    load2 = 0; tick();
    chk("t6_seg", 64'(seg2), 64'({7'b1001111, 7'b1111111}));
    digit_en2 = 2'b01; tick();
    chk("t6_blank", 64'(seg2), 64'({7'b0000000, 7'b1111111}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised, registered driver for a bank of 7-segment hex displays. It replaces the purely combinational switch-to-HEX decode. A multi-digit value is captured on a load strobe. Each digit is then decoded with per-digit enable, optional leading-zero blanking and per-digit blink from an internal prescaler. The block sits between the top-level data source (switches, CPU I/O register) and the HEX0..HEX7 board pins.

Parameters:
NUM_DIGITS, 8, number of displays driven (1..8).
BLINK_DIV, 25000000, clock cycles per blink half-period (>=1); 0.5 s at 50 MHz.
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board polarity); 0 = all seg bits inverted.

Ports:
clk  in  1  system clock (CLOCK_50 at top level).
rst_n  in  1  synchronous active-low reset.
load  in  1  capture strobe for value.
value  in  4*NUM_DIGITS  nibble i drives digit i; digit 0 is least significant.
blank_lz  in  1  1 = blank leading zero digits.
digit_en  in  NUM_DIGITS  0 = digit i forced blank.
blink_en  in  NUM_DIGITS  1 = digit i blinks.
seg  out  7*NUM_DIGITS  seg[7i+6:7i] drives digit i; bit0 = segment a … bit6 = segment g.
blink_phase  out  1  current blink phase; 1 = on half.

Behaviour:
- Reset is synchronous, sampled on the rising clk edge while rst_n=0:
  - value_q <= 0.
  - blink counter <= 0.
  - blink_phase <= 1.
  - Every seg digit <= 7'b1000000 ("0", active-low).
  - Reset wins over a simultaneous load.
- Capture: on an edge with load=1, value_q <= value. With load=0, value_q holds.
- Output register: seg is registered. It is computed each edge from value_q, blank_lz, digit_en, blink_en and blink_phase (the controls are sampled live, not latched).
- Latency:
  - load sampled at edge k → new glyphs on seg after edge k+1.
  - A change on any control input is visible after the next edge.
- Active-low decode (SEG_ACTIVE_LOW=1), hex glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Blank = 1111111.
  - SEG_ACTIVE_LOW=0: every bit inverted, including blank.
- Blank priority per digit i; blank if any of:
  - digit_en[i]=0;
  - blink_en[i]=1 and blink_phase=0;
  - blank_lz=1 and digit i is a leading zero.
- Leading zero definition:
  - Digit i (i>=1) is a leading zero iff nibbles i..NUM_DIGITS-1 of value_q are all zero.
  - Digit 0 is never blanked by blank_lz, so a value of 0 shows a single "0".
- Blink prescaler:
  - Counter of width clog2(BLINK_DIV) (min 1) counts 0..BLINK_DIV-1.
  - On the edge where it equals BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - Free-running; unaffected by load or the control inputs.
  - Period = 2*BLINK_DIV cycles.
  - BLINK_DIV=1 toggles phase every cycle.
- Unused upper digits do not exist; all widths scale with NUM_DIGITS.
- Mid-operation reset: the outputs show all "0" glyphs on the edge after rst_n is sampled low. Blink phase restarts at on.

Test Plan:
1. Reset, NUM_DIGITS=8, all digit_en=1 → every seg digit = 1000000. load value=0x0000_00F1 → after 2 edges: digit0=1111001, digit1=0001110, digits 2-7=1000000.
2. load value=0xA8D4_3C5E, blank_lz=0 → digits 0..7 = E,5,C,3,4,d,8,A. Sample check: digit2=1000110, digit6=0000000, digit7=0001000. Hold load=0 and change value → seg unchanged.
3. blank_lz=1, value_q=0x0000_0020 → digit1=0100100, digit0=1000000, digits 2-7=1111111. value_q=0 → only digit0 lit.
4. BLINK_DIV=4, blink_en=0x01, value_q=1 → digit0 toggles 1111001/1111111 every 4 cycles, and blink_phase matches. Digits without blink_en stay steady.
5. digit_en=0xFE → digit0 blank regardless of value and blink. Assert load and rst_n=0 together → value_q=0, seg all 1000000 next edge.
6. SEG_ACTIVE_LOW=0, NUM_DIGITS=2, value=0x38 → digit0=1111111, digit1=1001111, blank=0000000.
